// File: rtl/shift_seq_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_pkg
//
// Shared definitions for the shift step sequencer and the benches that sit
// next to the barrel_shifter:
//   - seqState_e   : IDLE / STEP / DONE states of the sequencer
//   - DEF_WIDTH    : default data width, matching the barrel_shifter
//   - DEF_AMT_W    : default barrel_shifter shift-amount width
//   - DEF_MAX_STEP : largest shift a single shifter pass can perform
//   - maxStep()    : MAX_STEP for an arbitrary shift-amount width
// ---------------------------------------------------------------------------
package shift_seq_pkg;

   // The three sequencer phases: waiting for a command, feeding passes
   // through the shifter, and presenting the result to the consumer.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } seqState_e;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_AMT_W = 2;

   // A shifter with an AMT_W-bit amount port can move at most 2^AMT_W-1
   // positions in one pass.
   function automatic int maxStep(input int amtW);
      return (1 << amtW) - 1;
   endfunction

   localparam int DEF_MAX_STEP = (1 << DEF_AMT_W) - 1;

endpackage

// File: rtl/shift_step_sequencer.sv
// ---------------------------------------------------------------------------
// shift_step_sequencer
//
// Takes one shift command (word, total amount, direction) per valid/ready
// handshake and breaks it into passes through an external combinational
// barrel shifter. Each pass shifts by at most MAX_STEP positions; the shifter
// output is registered between passes. The finished word and the number of
// passes used are offered on a valid/ready output.
//
// Valid for any shifter whose same-direction passes add up (logical shift or
// rotate), so the shifter itself lives one level up and can be swapped.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     command present
//   in_ready     sequencer can accept a command (IDLE only)
//   in_data      word to shift
//   in_amt       total shift amount
//   in_dir       direction, forwarded unchanged to the shifter
//   sh_data_in   to shifter data input
//   sh_amt       to shifter shift amount
//   sh_dir       to shifter direction
//   sh_data_out  from shifter data output (combinational return)
//   out_valid    result available
//   out_ready    consumer takes the result
//   out_data     shifted word
//   out_steps    number of shifter passes used
// ---------------------------------------------------------------------------
module shift_step_sequencer
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AMT_W = DEF_AMT_W,
   parameter int TOT_W = 4
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [TOT_W-1:0] in_amt,
   input  logic             in_dir,

   output logic [WIDTH-1:0] sh_data_in,
   output logic [AMT_W-1:0] sh_amt,
   output logic             sh_dir,
   input  logic [WIDTH-1:0] sh_data_out,

   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TOT_W-1:0] out_steps
);

   localparam int MAX_STEP = maxStep(AMT_W);

   seqState_e        state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [TOT_W-1:0] rem_q, rem_d;
   logic             dir_q, dir_d;
   logic [TOT_W-1:0] steps_q, steps_d;

   logic [AMT_W-1:0] stepAmt;
   logic [TOT_W-1:0] remAfter;

   // Size of the current pass: a full MAX_STEP while more than that remains,
   // otherwise whatever is left. Because stepAmt never exceeds rem_q the
   // remaining count cannot wrap below zero.
   always_comb begin
      if (rem_q > TOT_W'(MAX_STEP)) begin
         stepAmt = AMT_W'(MAX_STEP);
      end else begin
         stepAmt = rem_q[AMT_W-1:0];
      end
      remAfter = rem_q - TOT_W'(stepAmt);
   end

   // Next-state logic. Command fields are captured only at acceptance, so
   // the in_* pins are free to change while a command is in flight. In STEP
   // the shifter output loops straight back into the work register, which is
   // the only combinational path through the block.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
      steps_d = steps_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = in_data;
               rem_d   = in_amt;
               dir_d   = in_dir;
               steps_d = '0;
               state_d = (in_amt != '0) ? STEP : DONE;
            end
         end

         STEP: begin
            work_d  = sh_data_out;
            rem_d   = remAfter;
            steps_d = steps_q + TOT_W'(1);
            state_d = (remAfter == '0) ? DONE : STEP;
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset abandons any in-flight command outright; since
   // out_valid is decoded from DONE alone, no partial result can leak out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         steps_q <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         steps_q <= steps_d;
      end
   end

   // Output decode, all from registered state. Outside STEP the shifter is
   // given a zero amount so it just passes the held word through.
   always_comb begin
      in_ready   = (state_q == IDLE);
      out_valid  = (state_q == DONE);
      sh_data_in = work_q;
      sh_dir     = dir_q;
      sh_amt     = (state_q == STEP) ? stepAmt : '0;
      out_data   = (state_q == DONE) ? work_q : '0;
      out_steps  = (state_q == DONE) ? steps_q : '0;
   end

endmodule

// File: tb/tb_shift_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_step_sequencer
//
// Directed bench for shift_step_sequencer. The sh_* ports are closed through
// a rotate model (dir 0 = rotate left, dir 1 = rotate right). Inputs change
// and outputs are sampled on the falling edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_shift_step_sequencer;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic [3:0] in_amt;
   logic       in_dir;
   logic [3:0] sh_data_in;
   logic [1:0] sh_amt;
   logic       sh_dir;
   logic [3:0] sh_data_out;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [3:0] out_steps;

   int nAssert = 0;
   int nFail   = 0;

   shift_step_sequencer #(
      .WIDTH(4),
      .AMT_W(2),
      .TOT_W(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_amt     (in_amt),
      .in_dir     (in_dir),
      .sh_data_in (sh_data_in),
      .sh_amt     (sh_amt),
      .sh_dir     (sh_dir),
      .sh_data_out(sh_data_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_steps  (out_steps)
   );

   // Clock: 10 time units per cycle, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stand-in for the barrel shifter: rotate by doubling the word.
   function automatic logic [3:0] rotModel(input logic [3:0] d,
                                           input logic [1:0] a,
                                           input logic dr);
      logic [7:0] dd;
      logic [7:0] tmp;
      dd = {d, d};
      if (!dr) begin
         tmp = dd << a;
         return tmp[7:4];
      end else begin
         tmp = dd >> a;
         return tmp[3:0];
      end
   endfunction

   assign sh_data_out = rotModel(sh_data_in, sh_amt, sh_dir);

   // Single comparison point: counts every evaluation and every failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAssert++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Presents a command at a falling edge, lets the next rising edge take
   // it, then withdraws it and scrambles the pins to prove they were latched.
   // Returns at the falling edge just after acceptance.
   task automatic applyStimulus(input logic [3:0] d, input logic [3:0] a,
                                input logic dr);
      in_data  = d;
      in_amt   = a;
      in_dir   = dr;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~d;
      in_amt   = 4'd0;
      in_dir   = ~dr;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Hard stop in case something above waits forever.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [3:0] passData15 [5];

   initial begin
      passData15[0] = 4'b1101;
      passData15[1] = 4'b1011;
      passData15[2] = 4'b0111;
      passData15[3] = 4'b1110;
      passData15[4] = 4'b1101;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 4'd0;
      in_amt    = 4'd0;
      in_dir    = 1'b0;
      out_ready = 1'b1;

      // ---- reset values ----
      #2;
      checkOutput("rst in_ready",   32'(in_ready),   32'd1);
      checkOutput("rst out_valid",  32'(out_valid),  32'd0);
      checkOutput("rst out_data",   32'(out_data),   32'd0);
      checkOutput("rst out_steps",  32'(out_steps),  32'd0);
      checkOutput("rst sh_amt",     32'(sh_amt),     32'd0);
      checkOutput("rst sh_data_in", 32'(sh_data_in), 32'd0);
      checkOutput("rst sh_dir",     32'(sh_dir),     32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // ---- 1101 amt 5 left: passes 3 then 2, result 1011 ----
      applyStimulus(4'b1101, 4'd5, 1'b0);
      checkOutput("a5 p1 sh_amt",     32'(sh_amt),     32'd3);
      checkOutput("a5 p1 sh_data_in", 32'(sh_data_in), 32'hD);
      checkOutput("a5 p1 sh_dir",     32'(sh_dir),     32'd0);
      checkOutput("a5 p1 in_ready",   32'(in_ready),   32'd0);
      checkOutput("a5 p1 out_valid",  32'(out_valid),  32'd0);
      nextCycle();
      checkOutput("a5 p2 sh_amt",     32'(sh_amt),     32'd2);
      checkOutput("a5 p2 sh_data_in", 32'(sh_data_in), 32'hE);
      checkOutput("a5 p2 out_valid",  32'(out_valid),  32'd0);
      nextCycle();
      checkOutput("a5 out_valid",     32'(out_valid),  32'd1);
      checkOutput("a5 out_data",      32'(out_data),   32'hB);
      checkOutput("a5 out_steps",     32'(out_steps),  32'd2);
      checkOutput("a5 done sh_amt",   32'(sh_amt),     32'd0);
      nextCycle();
      checkOutput("a5 back idle",     32'(in_ready),   32'd1);
      checkOutput("a5 idle valid",    32'(out_valid),  32'd0);

      // ---- 1101 amt 0 right: straight to DONE, no passes ----
      checkOutput("a0 idle sh_amt",   32'(sh_amt),     32'd0);
      applyStimulus(4'b1101, 4'd0, 1'b1);
      checkOutput("a0 out_valid",     32'(out_valid),  32'd1);
      checkOutput("a0 out_data",      32'(out_data),   32'hD);
      checkOutput("a0 out_steps",     32'(out_steps),  32'd0);
      checkOutput("a0 sh_amt",        32'(sh_amt),     32'd0);
      nextCycle();
      checkOutput("a0 back idle",     32'(in_ready),   32'd1);
      checkOutput("a0 idle sh_amt",   32'(sh_amt),     32'd0);

      // ---- 1101 amt 15 right: five passes of 3, result 1011 ----
      applyStimulus(4'b1101, 4'd15, 1'b1);
      for (int p = 0; p < 5; p++) begin
         checkOutput($sformatf("a15 p%0d sh_amt", p),     32'(sh_amt),     32'd3);
         checkOutput($sformatf("a15 p%0d sh_data_in", p), 32'(sh_data_in), 32'(passData15[p]));
         checkOutput($sformatf("a15 p%0d sh_dir", p),     32'(sh_dir),     32'd1);
         checkOutput($sformatf("a15 p%0d out_valid", p),  32'(out_valid),  32'd0);
         nextCycle();
      end
      checkOutput("a15 out_valid",    32'(out_valid),  32'd1);
      checkOutput("a15 out_data",     32'(out_data),   32'hB);
      checkOutput("a15 out_steps",    32'(out_steps),  32'd5);
      nextCycle();

      // ---- backpressure on amt 5, second command held meanwhile ----
      out_ready = 1'b0;
      applyStimulus(4'b1101, 4'd5, 1'b0);
      nextCycle();
      nextCycle();
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
         checkOutput($sformatf("bp%0d out_data", i),  32'(out_data),  32'hB);
         checkOutput($sformatf("bp%0d out_steps", i), 32'(out_steps), 32'd2);
         checkOutput($sformatf("bp%0d in_ready", i),  32'(in_ready),  32'd0);
         in_data  = 4'b0011;
         in_amt   = 4'd1;
         in_dir   = 1'b0;
         in_valid = 1'b1;
         nextCycle();
      end
      out_ready = 1'b1;
      nextCycle();
      checkOutput("bp idle in_ready",  32'(in_ready),   32'd1);
      checkOutput("bp idle out_valid", 32'(out_valid),  32'd0);
      nextCycle();
      in_valid = 1'b0;
      checkOutput("bp2 sh_amt",        32'(sh_amt),     32'd1);
      checkOutput("bp2 sh_data_in",    32'(sh_data_in), 32'h3);
      checkOutput("bp2 in_ready",      32'(in_ready),   32'd0);
      nextCycle();
      checkOutput("bp2 out_valid",     32'(out_valid),  32'd1);
      checkOutput("bp2 out_data",      32'(out_data),   32'h6);
      checkOutput("bp2 out_steps",     32'(out_steps),  32'd1);
      nextCycle();

      // ---- reset during second pass of amt 7 ----
      applyStimulus(4'b1101, 4'd7, 1'b1);
      nextCycle();
      checkOutput("mr p2 sh_amt",      32'(sh_amt),     32'd3);
      checkOutput("mr p2 sh_dir",      32'(sh_dir),     32'd1);
      rst = 1'b1;
      #1;
      checkOutput("mr in_ready",       32'(in_ready),   32'd1);
      checkOutput("mr out_valid",      32'(out_valid),  32'd0);
      checkOutput("mr out_data",       32'(out_data),   32'd0);
      checkOutput("mr out_steps",      32'(out_steps),  32'd0);
      checkOutput("mr sh_amt",         32'(sh_amt),     32'd0);
      checkOutput("mr sh_data_in",     32'(sh_data_in), 32'd0);
      checkOutput("mr sh_dir",         32'(sh_dir),     32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'b0001, 4'd1, 1'b0);
      checkOutput("pr sh_amt",         32'(sh_amt),     32'd1);
      checkOutput("pr sh_data_in",     32'(sh_data_in), 32'h1);
      nextCycle();
      checkOutput("pr out_valid",      32'(out_valid),  32'd1);
      checkOutput("pr out_data",       32'(out_data),   32'h2);
      checkOutput("pr out_steps",      32'(out_steps),  32'd1);
      nextCycle();
      checkOutput("pr back idle",      32'(in_ready),   32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule

// File: doc/shift_step_sequencer.md
Name: shift_step_sequencer

Overview:
- Upstream command stage for the team's combinational barrel_shifter (4-bit data, 2-bit shift amount, 1-bit direction).
- Accepts one shift command per valid/ready handshake, with a total shift amount wider than the shifter's amount port.
- Issues the command as a series of shifter passes of at most 2^AMT_W-1 positions each, registering the shifter result between passes.
- Returns the final word on a valid/ready output; correct for any shifter whose same-direction passes compose additively (logical shift or rotate).

Parameters:
- WIDTH, 4: data word width; matches the barrel_shifter data width.
- AMT_W, 2: barrel_shifter shift-amount width; maximum step per pass is MAX_STEP = 2^AMT_W-1 = 3.
- TOT_W, 4: width of the requested total shift amount (0..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  command present.
- in_ready  output  1  sequencer can accept a command.
- in_data  input  WIDTH  word to shift.
- in_amt  input  TOT_W  total shift amount.
- in_dir  input  1  direction, passed unchanged to the shifter.
- sh_data_in  output  WIDTH  to barrel_shifter data_in.
- sh_amt  output  AMT_W  to barrel_shifter shift_amt.
- sh_dir  output  1  to barrel_shifter direction.
- sh_data_out  input  WIDTH  from barrel_shifter data_out (combinational return path).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  shifted word.
- out_steps  output  TOT_W  number of shifter passes used.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - work, rem, dir and steps registers clear to 0.
  - Outputs: in_ready=1 once IDLE, out_valid=0, out_data=0, out_steps=0, sh_amt=0, sh_data_in=0, sh_dir=0.
- Reset mid-operation drops the in-flight command; no partial result is ever presented.
- States:
  - IDLE: in_ready=1, out_valid=0. On a clk edge with in_valid=1, load work=in_data, rem=in_amt, dir=in_dir, steps=0. Next state is STEP if in_amt!=0, else DONE.
  - STEP: in_ready=0. Drive step = min(rem, MAX_STEP), with sh_data_in=work, sh_amt=step, sh_dir=dir. Each edge: work<=sh_data_out, rem<=rem-step, steps<=steps+1. Go to DONE when rem-step==0, otherwise stay in STEP.
  - DONE: out_valid=1, out_data=work, out_steps=steps. On an edge with out_ready=1, return to IDLE. Otherwise hold; out_data and out_steps stay stable under backpressure.
- In IDLE and DONE, drive sh_amt=0, sh_data_in=work and sh_dir=dir, so the shifter idles harmlessly.
- Pass count and latency:
  - Pass count N = ceil(in_amt/MAX_STEP). Every pass uses MAX_STEP except the last, which uses the remainder.
  - out_valid rises N+1 edges after the accepting edge; in_amt=0 gives N=0, so 1 edge.
- in_ready is high only in IDLE. No command is accepted while a result is pending; a throughput of one command per N+2 cycles minimum is the decided design.
- An in_valid pulse while in_ready=0 is ignored, not queued. The upstream holds in_valid until the handshake completes.
- in_dir is captured at acceptance; later changes on in_dir/in_data/in_amt do not affect the in-flight command.
- Arithmetic:
  - rem and steps are TOT_W-bit unsigned.
  - rem never underflows because step<=rem.
  - steps cannot overflow (N <= ceil(15/3) = 5 for the defaults).
- No combinational path from in_* to out_*. The only combinational path is sh_data_out to the work register's D input.

Decomposition:
- Package shift_seq_pkg holds:
  - the state enum IDLE/STEP/DONE;
  - the MAX_STEP constant derived from AMT_W;
  - a default WIDTH constant shared with the barrel_shifter bench.
- A single module is sufficient; no sub-module.
- The barrel_shifter is instantiated alongside the sequencer at the next level up, not inside it, so that alternative shifters can be swapped in.

Test Plan:
- The bench connects the sh_* ports to a rotate model: dir 0 = rotate left, dir 1 = rotate right.
- Command in_data=1101, in_amt=5, dir=0:
  - passes sh_amt=3 then 2, with sh_data_in 1101 then 1110;
  - out_data=1011, out_steps=2;
  - out_valid asserts 3 edges after acceptance.
- Command in_data=1101, in_amt=0, dir=1:
  - out_valid asserts 1 edge after acceptance;
  - out_data=1101, out_steps=0;
  - sh_amt stays 0 throughout.
- Command in_data=1101, in_amt=15, dir=1:
  - five passes of sh_amt=3;
  - out_data=1011, out_steps=5.
- Backpressure: complete the amt=5 case with out_ready=0 for 4 cycles.
  - out_valid, out_data=1011 and in_ready=0 hold stable.
  - A second in_valid during this window is not accepted.
  - Raising out_ready returns to IDLE; the held command is accepted on the next edge.
- Reset mid-operation: assert rst during the second pass of in_amt=7.
  - All outputs go to reset values immediately, with no clock edge needed.
  - After release, a fresh command in_data=0001, in_amt=1, dir=0 gives out_data=0010, out_steps=1.
